// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial converter.
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // A zero length field means "send the whole word".
  function automatic int eff_len(input int mod, input int data_w);
    return (mod == 0) ? data_w : mod;
  endfunction

endpackage

// File: rtl/param_serializer.sv
// Parallel-to-serial converter with one shift stage and one holding buffer,
// programmable length and bit order, and drop-with-error for short words.
module param_serializer
  import serializer_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int MOD_W   = $clog2(DATA_W),
  parameter int MIN_LEN = 3
) (
  input  logic              clk,
  input  logic              i_srst,
  input  logic [DATA_W-1:0] i_data,
  input  logic [MOD_W-1:0]  i_data_mod,
  input  logic              i_lsb_first,
  input  logic              i_data_val,
  output logic              o_ready,
  output logic              o_ser_data,
  output logic              o_ser_data_val,
  input  logic              i_ser_ready,
  output logic              o_ser_last,
  output logic              o_busy,
  output logic              o_mod_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_e            state_q;
  logic [DATA_W-1:0] sh_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              lsb_q;

  logic              buf_full_q;
  logic [DATA_W-1:0] buf_data_q;
  logic [CNT_W-1:0]  buf_len_q;
  logic              buf_lsb_q;

  logic              mod_err_q;

  logic [CNT_W-1:0]  in_len;
  logic              in_short;
  logic              accept;
  logic              legal;
  logic              shifting;
  logic              xfer;
  logic              last_bit;
  logic              last_xfer;

  assign in_len    = CNT_W'(eff_len(int'(i_data_mod), DATA_W));
  assign in_short  = (i_data_mod != '0) && (int'(i_data_mod) < MIN_LEN);
  assign accept    = i_data_val & ~buf_full_q;
  assign legal     = accept & ~in_short;
  assign shifting  = (state_q == SHIFT);
  assign xfer      = shifting & i_ser_ready;
  assign last_bit  = (cnt_q == len_q);
  assign last_xfer = xfer & last_bit;

  // Outputs depend on registers only; the active bit sits at the end selected by bit order.
  assign o_ready        = ~buf_full_q;
  assign o_ser_data_val = shifting;
  assign o_ser_data     = shifting & (lsb_q ? sh_q[0] : sh_q[DATA_W-1]);
  assign o_ser_last     = shifting & last_bit;
  assign o_busy         = shifting | buf_full_q;
  assign o_mod_err      = mod_err_q;

  always_ff @(posedge clk) begin
    if (i_srst) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      lsb_q      <= 1'b0;
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
      buf_len_q  <= '0;
      buf_lsb_q  <= 1'b0;
      mod_err_q  <= 1'b0;
    end else begin
      mod_err_q <= accept & in_short;
      if (!shifting || last_xfer) begin
        // Shift stage is free next cycle: refill from buffer first, then from input.
        if (shifting && buf_full_q) begin
          sh_q       <= buf_data_q;
          len_q      <= buf_len_q;
          lsb_q      <= buf_lsb_q;
          cnt_q      <= CNT_W'(1);
          buf_full_q <= 1'b0;
        end else if (legal) begin
          state_q <= SHIFT;
          sh_q    <= i_data;
          len_q   <= in_len;
          lsb_q   <= i_lsb_first;
          cnt_q   <= CNT_W'(1);
        end else if (shifting) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      end else begin
        if (xfer) begin
          sh_q  <= lsb_q ? (sh_q >> 1) : (sh_q << 1);
          cnt_q <= cnt_q + 1'b1;
        end
        if (legal) begin
          buf_full_q <= 1'b1;
          buf_data_q <= i_data;
          buf_len_q  <= in_len;
          buf_lsb_q  <= i_lsb_first;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_serializer.sv
// Bench for param_serializer: bit-queue reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_param_serializer;

  localparam int DATA_W = 16;
  localparam int MOD_W  = 4;

  logic              clk = 1'b0;
  logic              i_srst;
  logic [DATA_W-1:0] i_data;
  logic [MOD_W-1:0]  i_data_mod;
  logic              i_lsb_first;
  logic              i_data_val;
  logic              i_ser_ready;
  logic              o_ready, o_ser_data, o_ser_data_val, o_ser_last, o_busy, o_mod_err;

  param_serializer #(.DATA_W(DATA_W), .MOD_W(MOD_W), .MIN_LEN(3)) dut (
    .clk(clk), .i_srst(i_srst), .i_data(i_data), .i_data_mod(i_data_mod),
    .i_lsb_first(i_lsb_first), .i_data_val(i_data_val), .o_ready(o_ready),
    .o_ser_data(o_ser_data), .o_ser_data_val(o_ser_data_val),
    .i_ser_ready(i_ser_ready), .o_ser_last(o_ser_last), .o_busy(o_busy),
    .o_mod_err(o_mod_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every pending serial bit, in send order, tagged with last-of-word.
  typedef struct packed { bit b; bit l; } sb_t;
  sb_t mq[$];
  bit  merr_exp = 1'b0;
  bit  started  = 1'b0;
  int  cyc      = 0;
  int  acc_cyc  = 0;

  function automatic int inflight();
    int n = 0;
    foreach (mq[k]) if (mq[k].l) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    bit rdy;
    int len;
    int idx;
    cyc++;
    if (i_srst) begin
      mq.delete();
      merr_exp = 1'b0;
      started  = 1'b1;
    end else if (started) begin
      rdy = (inflight() < 2);
      if (mq.size() > 0 && i_ser_ready) void'(mq.pop_front());
      merr_exp = 1'b0;
      if (i_data_val && rdy) begin
        len = (i_data_mod == 0) ? DATA_W : int'(i_data_mod);
        if (i_data_mod != 0 && i_data_mod < 3) merr_exp = 1'b1;
        else begin
          acc_cyc = cyc - 1;
          for (int k = 0; k < len; k++) begin
            idx = i_lsb_first ? k : DATA_W - 1 - k;
            mq.push_back('{b: i_data[idx], l: (k == len - 1)});
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("ser_val",  o_ser_data_val, (mq.size() > 0));
      chk("ser_data", o_ser_data,     (mq.size() > 0) ? mq[0].b : 1'b0);
      chk("ser_last", o_ser_last,     (mq.size() > 0) ? mq[0].l : 1'b0);
      chk("ready",    o_ready,        (inflight() < 2));
      chk("busy",     o_busy,         (inflight() > 0));
      chk("mod_err",  o_mod_err,      merr_exp);
    end
  end

  // Capture of transferred bits for directed literal checks.
  typedef struct { bit b; bit l; int c; } cap_t;
  cap_t cap[$];
  int   merr_cnt = 0;

  always @(negedge clk) begin
    if (started && o_ser_data_val && i_ser_ready) cap.push_back('{o_ser_data, o_ser_last, cyc});
    if (o_mod_err) merr_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] m, input logic l);
    i_data = d; i_data_mod = m; i_lsb_first = l; i_data_val = 1'b1;
    tick();
    i_data_val = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (mq.size() != 0 && t < 300) begin tick(); t++; end
    if (t >= 300) chk("wait_idle_timeout", 1, 0);
    tick();
  endtask

  initial begin
    logic [15:0] g16;
    logic [7:0]  g8;
    int          t;
    i_srst = 1'b1; i_data = '0; i_data_mod = '0; i_lsb_first = 1'b0;
    i_data_val = 1'b1; i_ser_ready = 1'b1;
    tick(); tick();
    // Words offered during reset are ignored; outputs sit at reset values.
    chk("rst_ready", o_ready, 1);
    chk("rst_val",   o_ser_data_val, 0);
    chk("rst_busy",  o_busy, 0);
    chk("rst_err",   o_mod_err, 0);
    i_data_val = 1'b0;
    tick();
    i_srst = 1'b0;
    tick();

    // Full-width MSB-first word, first bit one cycle after accept.
    cap.delete();
    send(16'hA5C3, 4'd0, 1'b0);
    wait_idle();
    chk("a5c3_count", cap.size(), 16);
    if (cap.size() == 16) begin
      g16 = '0;
      foreach (cap[k]) g16 = {g16[14:0], cap[k].b};
      chk("a5c3_bits",  g16, 16'hA5C3);
      chk("a5c3_first", cap[0].c, acc_cyc + 1);
      chk("a5c3_lastc", cap[15].c, acc_cyc + 16);
      chk("a5c3_last15", cap[14].l, 0);
      chk("a5c3_last16", cap[15].l, 1);
    end

    // 8-bit LSB-first word.
    cap.delete();
    send(16'h00B5, 4'd8, 1'b1);
    wait_idle();
    chk("b5_count", cap.size(), 8);
    if (cap.size() == 8) begin
      g8 = '0;
      foreach (cap[k]) g8 = {g8[6:0], cap[k].b};
      chk("b5_bits", g8, 8'b10101101);
    end
    chk("b5_busy_after", o_busy, 0);

    // Back-to-back short words: second one buffered, no gap between them.
    cap.delete();
    send(16'hFFFF, 4'd4, 1'b0);
    send(16'h0000, 4'd4, 1'b0);
    chk("b2b_ready_low", o_ready, 0);
    wait_idle();
    chk("b2b_count", cap.size(), 8);
    if (cap.size() == 8) begin
      g8 = '0;
      foreach (cap[k]) g8 = {g8[6:0], cap[k].b};
      chk("b2b_bits", g8, 8'b11110000);
      chk("b2b_nogap", cap[7].c - cap[0].c, 7);
    end

    // Illegal length: dropped with a single error pulse.
    cap.delete();
    merr_cnt = 0;
    send(16'h1234, 4'd2, 1'b0);
    chk("short_ready", o_ready, 1);
    tick(); tick(); tick();
    chk("short_err_pulses", merr_cnt, 1);
    chk("short_no_bits", cap.size(), 0);

    // Downstream stall mid-word.
    cap.delete();
    send(16'hA5C3, 4'd0, 1'b0);
    tick(); tick(); tick();
    i_ser_ready = 1'b0;
    tick(); tick(); tick();
    i_ser_ready = 1'b1;
    wait_idle();
    chk("stall_count", cap.size(), 16);
    if (cap.size() == 16) begin
      g16 = '0;
      foreach (cap[k]) g16 = {g16[14:0], cap[k].b};
      chk("stall_bits", g16, 16'hA5C3);
    end

    // Reset mid-word with buffer full.
    cap.delete();
    send(16'hFFFF, 4'd0, 1'b0);
    send(16'hFFFF, 4'd0, 1'b0);
    t = 0;
    while (cap.size() < 4 && t < 50) begin tick(); t++; end
    if (t >= 50) chk("rst_mid_timeout", 1, 0);
    i_srst = 1'b1;
    tick();
    chk("rstmid_val",   o_ser_data_val, 0);
    chk("rstmid_data",  o_ser_data, 0);
    chk("rstmid_ready", o_ready, 1);
    chk("rstmid_busy",  o_busy, 0);
    i_srst = 1'b0;
    cap.delete();
    for (int k = 0; k < 20; k++) tick();
    chk("rstmid_no_bits", cap.size(), 0);

    // Randomized traffic with occasional stalls and resets.
    for (int k = 0; k < 3000; k++) begin
      i_data      = 16'($urandom);
      i_data_mod  = 4'($urandom_range(0, 15));
      i_lsb_first = 1'($urandom);
      i_data_val  = ($urandom_range(0, 99) < 50);
      i_ser_ready = ($urandom_range(0, 99) < 75);
      i_srst      = ($urandom_range(0, 199) == 0);
      tick();
    end
    i_data_val = 1'b0; i_ser_ready = 1'b1; i_srst = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
